// File: rtl/vec_mag_nd_if.sv
// Bus bundle for vec_mag_nd: APB slave port plus AXI-Stream input and output.
// The DUT connects through the slave modport; a driver/bench uses master.
interface vec_mag_nd_if #(
  parameter int NDIM           = 4,
  parameter int COORD_WIDTH    = 8,
  parameter int OUT_WIDTH      = 20,
  parameter int APB_ADDR_WIDTH = 12
);
  logic                          psel_i;
  logic                          penable_i;
  logic                          pwrite_i;
  logic [APB_ADDR_WIDTH-1:0]     paddr_i;
  logic [31:0]                   pwdata_i;
  logic [31:0]                   prdata_o;
  logic                          pready_o;
  logic                          pslverr_o;

  logic [NDIM*COORD_WIDTH-1:0]   s_axis_tdata;
  logic                          s_axis_tvalid;
  logic                          s_axis_tlast;
  logic                          s_axis_tready;

  logic [OUT_WIDTH-1:0]          m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tlast;
  logic                          m_axis_tready;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/vec_mag_nd.sv
// vec_mag_nd: per-beat L2^2 (MODE=0) or L1 (MODE=1) magnitude of NDIM signed
// coordinates, 3-stage stallable pipeline with saturating output and APB CSRs.
// Optional: define VEC_MAG_ND_PERF_EN to add the STALL_CNT register at 0x010.
module vec_mag_nd #(
  parameter int NDIM           = 4,
  parameter int COORD_WIDTH    = 8,
  parameter int OUT_WIDTH      = 20,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  vec_mag_nd_if.slave   bus
);

  localparam int CW = COORD_WIDTH;
  localparam int TW = 2 * CW;
  localparam int FW = 2 * CW + $clog2(NDIM);
  localparam int EW = (FW > OUT_WIDTH) ? FW : OUT_WIDTH;

  localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL   = APB_ADDR_WIDTH'(12'h000);
  localparam logic [APB_ADDR_WIDTH-1:0] A_STATUS = APB_ADDR_WIDTH'(12'h004);
  localparam logic [APB_ADDR_WIDTH-1:0] A_BEAT   = APB_ADDR_WIDTH'(12'h008);
  localparam logic [APB_ADDR_WIDTH-1:0] A_PKT    = APB_ADDR_WIDTH'(12'h00C);

  // Square or exact absolute value of one coordinate; -2^(CW-1) maps to +2^(CW-1).
  function automatic logic [TW-1:0] coord_term(input logic signed [CW-1:0] x, input logic mode);
    logic signed [CW:0]   xe;
    logic        [CW:0]   mag;
    logic signed [TW-1:0] sq;
    xe  = {x[CW-1], x};
    mag = xe[CW] ? $unsigned(-xe) : $unsigned(xe);
    sq  = TW'(x) * TW'(x);
    coord_term = mode ? TW'(mag) : $unsigned(sq);
  endfunction

  // Clamp to OUT_WIDTH bits; MSB of the result flags saturation.
  function automatic logic [OUT_WIDTH:0] saturate(input logic [FW-1:0] s);
    logic [EW-1:0] se;
    logic [EW-1:0] lim;
    se  = EW'(s);
    lim = EW'({OUT_WIDTH{1'b1}});
    if (se > lim) saturate = {1'b1, {OUT_WIDTH{1'b1}}};
    else          saturate = {1'b0, OUT_WIDTH'(se)};
  endfunction

  logic            ctrl_en_q, ctrl_en_d, ctrl_mode_q, ctrl_mode_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     beat_cnt_q, beat_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic            vld_p0_q, vld_p1_q, m_tvalid_q;
  logic            last_p0_q, last_p1_q, m_tlast_q;
  logic [TW-1:0]   term_d [NDIM];
  logic [TW-1:0]   term_p0_q [NDIM];
  logic [FW-1:0]   sum_d, sum_p1_q;
  logic [OUT_WIDTH-1:0] res_d, m_tdata_q;
  logic            sat_d, ovf_set;
  logic            adv, s_hs, m_hs, busy;
  logic            apb_acc, apb_wr, mapped, soft_rst;
  logic            sel_ctrl, sel_status, sel_beat, sel_pkt;
  logic [31:0]     prdata_d;
  logic            pslverr_d;
  logic            unused_pwdata;
`ifdef VEC_MAG_ND_PERF_EN
  localparam logic [APB_ADDR_WIDTH-1:0] A_STALL = APB_ADDR_WIDTH'(12'h010);
  logic            sel_stall;
  logic [31:0]     stall_cnt_q, stall_cnt_d;
`endif

  assign unused_pwdata = ^bus.pwdata_i[31:3];

  // Handshakes, stall control and APB address decode.
  always_comb begin
    adv        = !m_tvalid_q | bus.m_axis_tready;
    s_hs       = bus.s_axis_tvalid & adv & ctrl_en_q;
    m_hs       = m_tvalid_q & bus.m_axis_tready;
    busy       = vld_p0_q | vld_p1_q | m_tvalid_q;
    apb_acc    = bus.psel_i & bus.penable_i;
    apb_wr     = apb_acc & bus.pwrite_i;
    sel_ctrl   = (bus.paddr_i == A_CTRL);
    sel_status = (bus.paddr_i == A_STATUS);
    sel_beat   = (bus.paddr_i == A_BEAT);
    sel_pkt    = (bus.paddr_i == A_PKT);
    mapped     = sel_ctrl | sel_status | sel_beat | sel_pkt;
`ifdef VEC_MAG_ND_PERF_EN
    sel_stall  = (bus.paddr_i == A_STALL);
    mapped     = mapped | sel_stall;
`endif
    soft_rst   = apb_wr & sel_ctrl & bus.pwdata_i[1];
  end

  // Stage datapath: per-coordinate terms, their sum, and the clamped result.
  always_comb begin
    for (int k = 0; k < NDIM; k++) begin
      term_d[k] = coord_term($signed(bus.s_axis_tdata[k*CW +: CW]), ctrl_mode_q);
    end
    sum_d = '0;
    for (int k = 0; k < NDIM; k++) begin
      sum_d = sum_d + FW'(term_p0_q[k]);
    end
    {sat_d, res_d} = saturate(sum_p1_q);
    ovf_set = adv & vld_p1_q & sat_d;
  end

  // CSR next-state: SOFT_RST beats counter updates; an OVF set beats its W1C.
  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    ctrl_mode_d = ctrl_mode_q;
    if (apb_wr && sel_ctrl) begin
      ctrl_en_d   = bus.pwdata_i[0];
      ctrl_mode_d = bus.pwdata_i[2];
    end
    if (soft_rst)                                      ovf_d = 1'b0;
    else if (ovf_set)                                  ovf_d = 1'b1;
    else if (apb_wr && sel_status && bus.pwdata_i[1])  ovf_d = 1'b0;
    else                                               ovf_d = ovf_q;
    beat_cnt_d = soft_rst ? '0 : beat_cnt_q + 32'(m_hs);
    pkt_cnt_d  = soft_rst ? '0 : pkt_cnt_q + 32'(m_hs & m_tlast_q);
`ifdef VEC_MAG_ND_PERF_EN
    stall_cnt_d = soft_rst ? '0 : stall_cnt_q + 32'(m_tvalid_q & !bus.m_axis_tready);
`endif
  end

  // APB read data and error, combinational in the access phase only.
  always_comb begin
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if (apb_acc) begin
      if (!mapped)         pslverr_d = 1'b1;
      else if (sel_ctrl)   prdata_d  = {29'b0, ctrl_mode_q, 1'b0, ctrl_en_q};
      else if (sel_status) prdata_d  = {30'b0, ovf_q, busy};
      else if (sel_beat)   prdata_d  = beat_cnt_q;
      else if (sel_pkt)    prdata_d  = pkt_cnt_q;
`ifdef VEC_MAG_ND_PERF_EN
      else if (sel_stall)  prdata_d  = stall_cnt_q;
`endif
    end
  end

  // CSR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en_q   <= 1'b0;
      ctrl_mode_q <= 1'b0;
      ovf_q       <= 1'b0;
      beat_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
`ifdef VEC_MAG_ND_PERF_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      ctrl_en_q   <= ctrl_en_d;
      ctrl_mode_q <= ctrl_mode_d;
      ovf_q       <= ovf_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
`ifdef VEC_MAG_ND_PERF_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  // Pipeline control and output register; SOFT_RST drops every beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      m_tvalid_q <= 1'b0;
      last_p0_q  <= 1'b0;
      last_p1_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else if (soft_rst) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else if (adv) begin
      // S1 -> S2 -> S3 boundaries
      vld_p0_q   <= s_hs;
      last_p0_q  <= bus.s_axis_tlast;
      vld_p1_q   <= vld_p0_q;
      last_p1_q  <= last_p0_q;
      m_tvalid_q <= vld_p1_q;
      m_tlast_q  <= last_p1_q;
      m_tdata_q  <= res_d;
    end
  end

  // Datapath registers carry no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      term_p0_q <= term_d;
      sum_p1_q  <= sum_d;
    end
  end

  assign bus.s_axis_tready = adv & ctrl_en_q;
  assign bus.m_axis_tvalid = m_tvalid_q;
  assign bus.m_axis_tdata  = m_tdata_q;
  assign bus.m_axis_tlast  = m_tlast_q;
  assign bus.prdata_o      = prdata_d;
  assign bus.pslverr_o     = pslverr_d;
  assign bus.pready_o      = 1'b1;

endmodule

// File: tb/tb_vec_mag_nd.sv
// Bench for vec_mag_nd (OUT_WIDTH=16 so saturation is reachable).
module tb_vec_mag_nd;
  localparam int NDIM = 4;
  localparam int CW   = 8;
  localparam int OW   = 16;
  localparam int AW   = 12;
  localparam longint MAXO = (64'd1 << OW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec_mag_nd_if #(.NDIM(NDIM), .COORD_WIDTH(CW), .OUT_WIDTH(OW), .APB_ADDR_WIDTH(AW)) bus();
  vec_mag_nd #(.NDIM(NDIM), .COORD_WIDTH(CW), .OUT_WIDTH(OW), .APB_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  longint exp_data[$];
  bit     exp_last[$];
  bit     stab_en = 1'b1;
  bit     prev_stall = 1'b0;
  longint prev_data = 0;
  int     stall_obs = 0;
  bit     model_ovf = 1'b0;
  bit     rnd_rdy = 1'b0;
  int     beats_sent = 0;
  int     pkts_sent = 0;
  logic   apb_err;
  logic [31:0] rd;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: sum of squares or of absolute values, clamped to OUT_WIDTH.
  function automatic longint ref_mag(input logic [NDIM*CW-1:0] c, input bit mode, output bit sat);
    longint s = 0;
    for (int k = 0; k < NDIM; k++) begin
      int x = int'($signed(c[k*CW +: CW]));
      s += mode ? ((x < 0) ? -x : x) : x * x;
    end
    sat = (s > MAXO);
    return sat ? MAXO : s;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1;
    bus.paddr_i = a; bus.pwdata_i = d;
    tick();
    bus.penable_i = 1'b1;
    #1 apb_err = bus.pslverr_o;
    @(posedge clk); #1;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = a;
    tick();
    bus.penable_i = 1'b1;
    #1;
    d = bus.prdata_o;
    apb_err = bus.pslverr_o;
    @(posedge clk); #1;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
  endtask

  task automatic send_beat(input logic [NDIM*CW-1:0] c, input bit mode, input bit last);
    bit sat;
    bit done = 1'b0;
    bus.s_axis_tdata = c; bus.s_axis_tvalid = 1'b1; bus.s_axis_tlast = last;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.s_axis_tready) begin
        exp_data.push_back(ref_mag(c, mode, sat));
        exp_last.push_back(last);
        if (sat) model_ovf = 1'b1;
        beats_sent++;
        if (last) pkts_sent++;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.s_axis_tvalid = 1'b0;
    if (!done) check("s_ready_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && exp_data.size() != 0; i++) tick();
    check("drain", exp_data.size(), 0);
  endtask

  function automatic logic [NDIM*CW-1:0] rand_coords();
    logic [NDIM*CW-1:0] c;
    for (int k = 0; k < NDIM; k++)
      c[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? 8'h80 : CW'($urandom);
    return c;
  endfunction

  // Output scoreboard and stall-stability monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stab_en && prev_stall) begin
        check("stall_tvalid", bus.m_axis_tvalid, 1);
        check("stall_tdata", bus.m_axis_tdata, prev_data);
      end
      if (bus.m_axis_tvalid && !bus.m_axis_tready) stall_obs++;
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_data  = bus.m_axis_tdata;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_data.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          check("tdata", bus.m_axis_tdata, exp_data.pop_front());
          check("tlast", bus.m_axis_tlast, exp_last.pop_front());
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      if (rnd_rdy) bus.m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0; bus.paddr_i = '0; bus.pwdata_i = '0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.m_axis_tready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", bus.m_axis_tvalid, 0);
    check("rst_tdata", bus.m_axis_tdata, 0);
    check("rst_tlast", bus.m_axis_tlast, 0);
    check("rst_prdata", bus.prdata_o, 0);
    check("rst_pslverr", bus.pslverr_o, 0);
    check("rst_s_tready", bus.s_axis_tready, 0);
    rst_n = 1'b1;
    tick();
    apb_read(12'h000, rd); check("rst_ctrl", rd, 0);
    apb_read(12'h004, rd); check("rst_status", rd, 0);
    apb_read(12'h008, rd); check("rst_beat", rd, 0);

    // T1: {3,-4,0,0} sum of squares, latency 3
    apb_write(12'h000, 32'h1);
    send_beat(32'h0000FC03, 1'b0, 1'b1);
    check("t1_lat_a", bus.m_axis_tvalid, 0);
    tick(); check("t1_lat_b", bus.m_axis_tvalid, 0);
    tick(); check("t1_vld", bus.m_axis_tvalid, 1);
    check("t1_data", bus.m_axis_tdata, 25);
    check("t1_last", bus.m_axis_tlast, 1);
    wait_drain();
    apb_read(12'h008, rd); check("t1_beat_cnt", rd, 1);
    apb_read(12'h00C, rd); check("t1_pkt_cnt", rd, 1);

    // T2: {-128,127,-1,0} in L1 then L2^2
    apb_write(12'h000, 32'h5);
    send_beat(32'h00FF7F80, 1'b1, 1'b0);
    apb_write(12'h000, 32'h1);
    send_beat(32'h00FF7F80, 1'b0, 1'b1);
    wait_drain();

    // T3: saturation and OVF W1C
    send_beat(32'h80808080, 1'b0, 1'b1);
    wait_drain();
    apb_read(12'h004, rd); check("t3_ovf_set", rd[1], 1);
    apb_write(12'h004, 32'h2);
    apb_read(12'h004, rd); check("t3_ovf_clr", rd[1], 0);
    model_ovf = 1'b0;

    // T4: random back-to-back beats under random backpressure, both modes
    rnd_rdy = 1'b1;
    for (int i = 0; i < 20; i++) send_beat(rand_coords(), 1'b0, (i % 5) == 4);
    apb_write(12'h000, 32'h5);
    for (int i = 0; i < 20; i++) send_beat(rand_coords(), 1'b1, (i % 5) == 4);
    wait_drain();
    rnd_rdy = 1'b0;
    tick();
    bus.m_axis_tready = 1'b1;
    tick();
    apb_read(12'h004, rd);
    check("t4_busy", rd[0], 0);
    check("t4_ovf", rd[1], model_ovf);
    apb_read(12'h008, rd); check("t4_beat_cnt", rd, beats_sent);
    apb_read(12'h00C, rd); check("t4_pkt_cnt", rd, pkts_sent);
`ifdef VEC_MAG_ND_PERF_EN
    apb_read(12'h010, rd); check("t4_stall_cnt", rd, stall_obs);
    check("t4_stall_err", apb_err, 0);
`else
    apb_read(12'h010, rd);
    check("t4_stall_unmapped_err", apb_err, 1);
    check("t4_stall_unmapped_data", rd, 0);
`endif

    // T5: soft reset with three beats in flight
    apb_write(12'h000, 32'h1);
    stab_en = 1'b0;
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(rand_coords(), 1'b0, 1'b1);
    apb_write(12'h000, 32'h3);
    exp_data.delete(); exp_last.delete();
    beats_sent = 0; pkts_sent = 0; stall_obs = 0; model_ovf = 1'b0;
    bus.m_axis_tready = 1'b1;
    repeat (10) tick();
    stab_en = 1'b1;
    apb_read(12'h004, rd); check("t5_status", rd, 0);
    apb_read(12'h008, rd); check("t5_beat_cnt", rd, 0);
    apb_read(12'h000, rd); check("t5_ctrl", rd, 1);

    // T6: unmapped read, write to read-only counter
    apb_read(12'h020, rd);
    check("t6_err", apb_err, 1);
    check("t6_data", rd, 0);
    apb_write(12'h008, 32'h1234);
    check("t6_ro_err", apb_err, 0);
    apb_read(12'h008, rd); check("t6_ro_cnt", rd, 0);

    // Asynchronous reset while a result is waiting on the output
    stab_en = 1'b0;
    bus.m_axis_tready = 1'b0;
    send_beat(32'h00000505, 1'b0, 1'b0);
    send_beat(32'h00000707, 1'b0, 1'b1);
    tick();
    check("arst_pre_vld", bus.m_axis_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", bus.m_axis_tvalid, 0);
    check("arst_tdata", bus.m_axis_tdata, 0);
    check("arst_tlast", bus.m_axis_tlast, 0);
    exp_data.delete(); exp_last.delete();
    tick();
    rst_n = 1'b1;
    bus.m_axis_tready = 1'b1;
    tick();
    apb_read(12'h000, rd); check("arst_ctrl", rd, 0);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
